// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory stage controller: dcache handshake, control redirect, writeback latch
// Requests are driven straight from the execute latch, which mem_stall keeps frozen while a miss is pending.
module mem_stage_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ex_pc_plus_4,
  input  logic [31:0] ex_baddr,
  input  logic [31:0] ex_jaddr,
  input  logic [31:0] ex_portout,
  input  logic [31:0] ex_rdat2,
  input  logic        ex_zero,
  input  logic        ex_Branch,
  input  logic        ex_bne,
  input  logic        ex_Jump,
  input  logic        ex_JAL,
  input  logic        ex_MemtoReg,
  input  logic        ex_regWEN,
  input  logic        ex_halt,
  input  logic        ex_dREN,
  input  logic        ex_dWEN,
  input  logic [4:0]  ex_wsel,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        wb_regWEN,
  output logic        wb_halt,
  output logic [4:0]  wb_wsel,
  output logic [31:0] wb_wdat
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        w_halted;
  logic        w_req;
  logic        w_stall;
  logic        w_taken;
  logic [31:0] w_wdat;
  logic        r_wb_regwen;
  logic        r_wb_halt;
  logic [4:0]  r_wb_wsel;
  logic [31:0] r_wb_wdat;

  assign w_halted = (r_state == HALTED);
  assign w_req    = !w_halted && (ex_dREN || ex_dWEN);
  assign w_stall  = w_req && !dhit;
  assign w_taken  = ex_Branch && (ex_zero ^ ex_bne);

  // A combined read+write request is issued as a write only.
  assign dmemWEN     = w_req && ex_dWEN;
  assign dmemREN     = w_req && ex_dREN && !ex_dWEN;
  assign dmemaddr    = ex_portout;
  assign dmemstore   = ex_rdat2;
  assign mem_stall   = w_stall;
  assign redirect    = (w_taken || ex_Jump) && !w_stall && !w_halted;
  assign redirect_pc = ex_Jump ? ex_jaddr : ex_baddr;

  assign w_wdat = ex_JAL ? ex_pc_plus_4 : (ex_MemtoReg ? dmemload : ex_portout);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ACCESS: begin
        if (w_stall)      w_next = ACCESS;
        else if (ex_halt) w_next = HALTED;
        else              w_next = IDLE;
      end
      HALTED:  w_next = HALTED;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_wb_regwen <= 1'b0;
      r_wb_halt   <= 1'b0;
      r_wb_wsel   <= 5'd0;
      r_wb_wdat   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_halted) begin
        r_wb_regwen <= 1'b0;
        r_wb_halt   <= 1'b1;
      end else if (w_stall) begin
        r_wb_regwen <= 1'b0;
      end else begin
        r_wb_regwen <= ex_regWEN;
        r_wb_halt   <= ex_halt;
        r_wb_wsel   <= ex_JAL ? 5'd31 : ex_wsel;
        r_wb_wdat   <= w_wdat;
      end
    end
  end

  assign wb_regWEN = r_wb_regwen;
  assign wb_halt   = r_wb_halt;
  assign wb_wsel   = r_wb_wsel;
  assign wb_wdat   = r_wb_wdat;

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low; ports named CLK and nRST.
REQ-002 SHALL have ports (name direction width meaning):
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- ex_pc_plus_4, ex_baddr, ex_jaddr, ex_portout, ex_rdat2  in  32 each  execute latch outputs: PC+4, branch target, jump target, ALU result, store data
- ex_zero, ex_Branch, ex_bne, ex_Jump, ex_JAL, ex_MemtoReg, ex_regWEN, ex_halt, ex_dREN, ex_dWEN  in  1 each  execute latch control outputs
- ex_wsel  in  5  destination register
- dhit  in  1  dcache access complete
- dmemload  in  32  dcache read data, valid when dhit
- dmemREN, dmemWEN  out  1 each  dcache request
- dmemaddr, dmemstore  out  32 each  dcache address, store data
- mem_stall  out  1  stage busy; drives execute latch en low
- redirect  out  1  control transfer taken; drives upstream latch flush
- redirect_pc  out  32  new PC
- wb_regWEN, wb_halt  out  1 each  writeback latch controls
- wb_wsel  out  5  writeback destination
- wb_wdat  out  32  writeback data

Function
REQ-003 SHALL implement a 3-state FSM: IDLE, ACCESS, HALTED.
REQ-004 IDLE with ex_dREN or ex_dWEN high SHALL assert the request combinationally that cycle: dmemaddr = ex_portout, dmemstore = ex_rdat2.
REQ-005 ex_dREN and ex_dWEN both high SHALL issue write only (dmemWEN=1, dmemREN=0).
REQ-006 IDLE request with dhit in the same cycle SHALL complete with zero stall; otherwise next state is ACCESS.
REQ-007 ACCESS SHALL hold the request and its address/data stable, with mem_stall=1 every cycle until dhit; the dhit cycle has mem_stall=0 and next state IDLE.
REQ-008 mem_stall SHALL equal (request asserted) AND NOT dhit, in IDLE and ACCESS alike.
REQ-009 Branch taken SHALL be ex_Branch AND (ex_zero XOR ex_bne).
REQ-010 redirect SHALL be (taken OR ex_Jump) AND NOT mem_stall AND state != HALTED; combinational.
REQ-011 redirect_pc SHALL be ex_jaddr when ex_Jump, else ex_baddr; ex_Jump takes priority over a taken branch.
REQ-012 Writeback outputs SHALL be registered, updated only on cycles with mem_stall=0.
REQ-013 On a stalled cycle, wb_regWEN SHALL register 0 (bubble); wb_wsel/wb_wdat hold.
REQ-014 wb_wdat SHALL be ex_pc_plus_4 if ex_JAL; else dmemload if ex_MemtoReg; else ex_portout.
REQ-015 wb_wsel SHALL be 31 when ex_JAL, else ex_wsel.
REQ-016 ex_halt on a non-stalled cycle SHALL register wb_halt=1 and enter HALTED; the halt beat's own wb_regWEN follows ex_regWEN.
REQ-017 HALTED SHALL be absorbing until reset: dmemREN=dmemWEN=0, redirect=0, mem_stall=0, wb_regWEN=0, wb_halt=1.
REQ-018 ex_halt with a pending memory access SHALL complete the access first; halt takes effect on the dhit cycle.

Reset
REQ-019 nRST low SHALL force state IDLE and wb_regWEN=0, wb_halt=0, wb_wsel=0, wb_wdat=0 immediately, regardless of CLK.
REQ-020 Combinational outputs SHALL follow from IDLE during reset; an access in flight is abandoned and not resumed.

Verification
REQ-021 Load, dhit 3 cycles late: ex_dREN=1, ex_portout=0x100, MemtoReg=1, wsel=5; dmemload=0xDEADBEEF with dhit on cycle 3 -> mem_stall=1 for cycles 0-2, dmemaddr=0x100 held; next edge wb_wdat=0xDEADBEEF, wb_wsel=5, wb_regWEN=1.
REQ-022 BNE taken: Branch=1, bne=1, zero=0, baddr=0x40 -> redirect=1, redirect_pc=0x40 same cycle; bne=0 with zero=0 -> redirect=0.
REQ-023 JAL: Jump=1, JAL=1, jaddr=0x200, pc_plus_4=0x14 -> redirect_pc=0x200; next edge wb_wsel=31, wb_wdat=0x14.
REQ-024 Store same-cycle hit with ex_dREN=ex_dWEN=1, dhit=1, rdat2=0x55 -> dmemWEN=1, dmemREN=0, dmemstore=0x55, mem_stall=0.
REQ-025 halt behind pending load: dREN=1, halt=1, dhit after 2 cycles -> wb_halt=1 only after dhit edge; thereafter ex_dWEN=1 yields no dmem request, redirect=0.
REQ-026 nRST low mid-ACCESS -> dmemREN drops and wb outputs zero immediately; after release, a new request starts from IDLE.
